// File: rtl/spu_regfile_fwd.sv
// SPU-Lite register file with operand forwarding: 128 x 128-bit array, two write-back
// ports, and six forwarding taps per pipe resolved youngest-first for RA/RB/RC.
module spu_regfile_fwd #(
  parameter int REG_ADDR_WD = 7,
  parameter int REG_DATA_WD = 128,
  parameter int NUM_FWD     = 6
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           rd_req,
  input  logic [REG_ADDR_WD-1:0]         rd_addr_ra,
  input  logic [REG_ADDR_WD-1:0]         rd_addr_rb,
  input  logic [REG_ADDR_WD-1:0]         rd_addr_rc,
  output logic                           rd_vld,
  output logic [REG_DATA_WD-1:0]         rd_data_ra,
  output logic [REG_DATA_WD-1:0]         rd_data_rb,
  output logic [REG_DATA_WD-1:0]         rd_data_rc,
  input  logic                           wr_en_ep,
  input  logic [REG_ADDR_WD-1:0]         wr_addr_ep,
  input  logic [REG_DATA_WD-1:0]         wr_data_ep,
  input  logic                           wr_en_op,
  input  logic [REG_ADDR_WD-1:0]         wr_addr_op,
  input  logic [REG_DATA_WD-1:0]         wr_data_op,
  input  logic [NUM_FWD-1:0]             fwd_vld_ep,
  input  logic [NUM_FWD*REG_ADDR_WD-1:0] fwd_addr_ep,
  input  logic [NUM_FWD*REG_DATA_WD-1:0] fwd_data_ep,
  input  logic [NUM_FWD-1:0]             fwd_vld_op,
  input  logic [NUM_FWD*REG_ADDR_WD-1:0] fwd_addr_op,
  input  logic [NUM_FWD*REG_DATA_WD-1:0] fwd_data_op,
  output logic                           wr_conflict
);

  localparam int NUM_REGS = 1 << REG_ADDR_WD;

  logic [REG_DATA_WD-1:0] mem_q [NUM_REGS];
  logic [REG_DATA_WD-1:0] ra_q, rb_q, rc_q;
  logic                   vld_q;
  logic                   conflict_q;
  logic                   conflict_d;
  logic [REG_ADDR_WD-1:0] src [3];

  assign src[0] = rd_addr_ra;
  assign src[1] = rd_addr_rb;
  assign src[2] = rd_addr_rc;

  assign conflict_d = wr_en_ep && wr_en_op && (wr_addr_ep == wr_addr_op);

  // Lowest priority is applied first so later overrides win: array, even WB, odd WB,
  // then taps from oldest (s7) to youngest (s2), odd before even at each stage.
  for (genvar k = 0; k < 3; k++) begin : g_opnd
    logic [REG_DATA_WD-1:0] opnd_d;
    always_comb begin
      opnd_d = mem_q[src[k]];
      if (wr_en_ep && (wr_addr_ep == src[k])) opnd_d = wr_data_ep;
      if (wr_en_op && (wr_addr_op == src[k])) opnd_d = wr_data_op;
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
        if (fwd_vld_op[i] && (fwd_addr_op[i*REG_ADDR_WD +: REG_ADDR_WD] == src[k]))
          opnd_d = fwd_data_op[i*REG_DATA_WD +: REG_DATA_WD];
        if (fwd_vld_ep[i] && (fwd_addr_ep[i*REG_ADDR_WD +: REG_ADDR_WD] == src[k]))
          opnd_d = fwd_data_ep[i*REG_DATA_WD +: REG_DATA_WD];
      end
    end
  end

  // Odd write is issued second so it lands on a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else begin
      if (wr_en_ep) mem_q[wr_addr_ep] <= wr_data_ep;
      if (wr_en_op) mem_q[wr_addr_op] <= wr_data_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q      <= 1'b0;
      ra_q       <= '0;
      rb_q       <= '0;
      rc_q       <= '0;
      conflict_q <= 1'b0;
    end else begin
      vld_q      <= rd_req;
      conflict_q <= conflict_d;
      if (rd_req) begin
        ra_q <= g_opnd[0].opnd_d;
        rb_q <= g_opnd[1].opnd_d;
        rc_q <= g_opnd[2].opnd_d;
      end
    end
  end

  assign rd_vld      = vld_q;
  assign rd_data_ra  = ra_q;
  assign rd_data_rb  = rb_q;
  assign rd_data_rc  = rc_q;
  assign wr_conflict = conflict_q;

endmodule

// File: tb/tb_spu_regfile_fwd.sv
// Self-checking bench for spu_regfile_fwd: directed scenarios plus randomized traffic
// against a priority-search reference model.
module tb_spu_regfile_fwd;

  localparam int AW = 7;
  localparam int DW = 128;
  localparam int NF = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rd_req;
  logic [AW-1:0] rd_addr_ra, rd_addr_rb, rd_addr_rc;
  logic rd_vld;
  logic [DW-1:0] rd_data_ra, rd_data_rb, rd_data_rc;
  logic wr_en_ep, wr_en_op;
  logic [AW-1:0] wr_addr_ep, wr_addr_op;
  logic [DW-1:0] wr_data_ep, wr_data_op;
  logic [NF-1:0] fwd_vld_ep, fwd_vld_op;
  logic [NF*AW-1:0] fwd_addr_ep, fwd_addr_op;
  logic [NF*DW-1:0] fwd_data_ep, fwd_data_op;
  logic wr_conflict;

  logic [AW-1:0] fa_ep [NF];
  logic [AW-1:0] fa_op [NF];
  logic [DW-1:0] fd_ep [NF];
  logic [DW-1:0] fd_op [NF];

  logic [DW-1:0] model_mem [128];
  logic [DW-1:0] last_ra, last_rb, last_rc;
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  always_comb begin
    fwd_addr_ep = '0;
    fwd_addr_op = '0;
    fwd_data_ep = '0;
    fwd_data_op = '0;
    for (int s = 0; s < NF; s++) begin
      fwd_addr_ep[s*AW +: AW] = fa_ep[s];
      fwd_addr_op[s*AW +: AW] = fa_op[s];
      fwd_data_ep[s*DW +: DW] = fd_ep[s];
      fwd_data_op[s*DW +: DW] = fd_op[s];
    end
  end

  spu_regfile_fwd dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_addr_ra(rd_addr_ra), .rd_addr_rb(rd_addr_rb), .rd_addr_rc(rd_addr_rc),
    .rd_vld(rd_vld), .rd_data_ra(rd_data_ra), .rd_data_rb(rd_data_rb), .rd_data_rc(rd_data_rc),
    .wr_en_ep(wr_en_ep), .wr_addr_ep(wr_addr_ep), .wr_data_ep(wr_data_ep),
    .wr_en_op(wr_en_op), .wr_addr_op(wr_addr_op), .wr_data_op(wr_data_op),
    .fwd_vld_ep(fwd_vld_ep), .fwd_addr_ep(fwd_addr_ep), .fwd_data_ep(fwd_data_ep),
    .fwd_vld_op(fwd_vld_op), .fwd_addr_op(fwd_addr_op), .fwd_data_op(fwd_data_op),
    .wr_conflict(wr_conflict)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference: scan sources from youngest to oldest and take the first hit.
  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    for (int s = 0; s < NF; s++) begin
      if (fwd_vld_ep[s] && fa_ep[s] == a) return fd_ep[s];
      if (fwd_vld_op[s] && fa_op[s] == a) return fd_op[s];
    end
    if (wr_en_op && wr_addr_op == a) return wr_data_op;
    if (wr_en_ep && wr_addr_ep == a) return wr_data_ep;
    return model_mem[a];
  endfunction

  task automatic idle();
    rd_req = 0; rd_addr_ra = 0; rd_addr_rb = 0; rd_addr_rc = 0;
    wr_en_ep = 0; wr_addr_ep = 0; wr_data_ep = 0;
    wr_en_op = 0; wr_addr_op = 0; wr_data_op = 0;
    fwd_vld_ep = 0; fwd_vld_op = 0;
    for (int s = 0; s < NF; s++) begin
      fa_ep[s] = 0; fa_op[s] = 0; fd_ep[s] = 0; fd_op[s] = 0;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 128; i++) model_mem[i] = '0;
    last_ra = '0; last_rb = '0; last_rc = '0;
  endtask

  // One clock: predict from current inputs, clock, compare, then commit writes to the model.
  task automatic step();
    logic exp_req, exp_conf;
    logic [DW-1:0] e_ra, e_rb, e_rc;
    exp_req  = rd_req;
    exp_conf = wr_en_ep && wr_en_op && (wr_addr_ep == wr_addr_op);
    if (exp_req) begin
      e_ra = ref_read(rd_addr_ra);
      e_rb = ref_read(rd_addr_rb);
      e_rc = ref_read(rd_addr_rc);
    end else begin
      e_ra = last_ra; e_rb = last_rb; e_rc = last_rc;
    end
    @(posedge clk);
    #1;
    check("rd_vld", {127'b0, rd_vld}, {127'b0, exp_req});
    check("wr_conflict", {127'b0, wr_conflict}, {127'b0, exp_conf});
    check("rd_data_ra", rd_data_ra, e_ra);
    check("rd_data_rb", rd_data_rb, e_rb);
    check("rd_data_rc", rd_data_rc, e_rc);
    last_ra = e_ra; last_rb = e_rb; last_rc = e_rc;
    if (wr_en_ep) model_mem[wr_addr_ep] = wr_data_ep;
    if (wr_en_op) model_mem[wr_addr_op] = wr_data_op;
  endtask

  initial begin
    idle();
    model_clear();
    #2;
    check("reset_vld", {127'b0, rd_vld}, '0);
    check("reset_ra", rd_data_ra, '0);
    check("reset_conflict", {127'b0, wr_conflict}, '0);
    #20 rst_n = 1;

    // Read from a freshly reset file
    rd_req = 1; rd_addr_ra = 5; rd_addr_rb = 6; rd_addr_rc = 127;
    step();
    check("post_reset_rc", rd_data_rc, '0);

    // Write, start a read, then reset mid-read
    idle(); wr_en_ep = 1; wr_addr_ep = 77; wr_data_ep = {32{4'h9}};
    step();
    idle(); rd_req = 1; rd_addr_ra = 77;
    step();
    check("pre_mid_reset_vld", {127'b0, rd_vld}, 128'd1);
    rst_n = 0;
    #1;
    check("mid_reset_vld", {127'b0, rd_vld}, '0);
    check("mid_reset_ra", rd_data_ra, '0);
    model_clear();
    #2 rst_n = 1;
    idle(); rd_req = 1; rd_addr_ra = 77;
    step();
    check("after_reset_ra77", rd_data_ra, '0);

    // Plain write then read
    idle(); wr_en_ep = 1; wr_addr_ep = 10; wr_data_ep = {16{8'hA5}};
    step();
    idle(); rd_req = 1; rd_addr_ra = 10;
    step();
    check("array_read", rd_data_ra, {16{8'hA5}});

    // Write-through on the odd port
    idle(); wr_en_op = 1; wr_addr_op = 20; wr_data_op = 128'h1234; rd_req = 1; rd_addr_ra = 20;
    step();
    check("write_through", rd_data_ra, 128'h1234);

    // Forward priority
    idle(); wr_en_ep = 1; wr_addr_ep = 30; wr_data_ep = 128'h1;
    step();
    idle(); rd_req = 1; rd_addr_ra = 30;
    fwd_vld_op[5] = 1; fa_op[5] = 30; fd_op[5] = 128'h7;
    fwd_vld_ep[2] = 1; fa_ep[2] = 30; fd_ep[2] = 128'h4;
    fwd_vld_op[0] = 0; fa_op[0] = 30; fd_op[0] = 128'h2;
    step();
    check("fwd_s4_wins", rd_data_ra, 128'h4);
    fwd_vld_op[0] = 1;
    step();
    check("fwd_s2_wins", rd_data_ra, 128'h2);

    // Same-stage tie: even beats odd
    idle(); rd_req = 1; rd_addr_ra = 40;
    fwd_vld_ep[1] = 1; fa_ep[1] = 40; fd_ep[1] = 128'hE;
    fwd_vld_op[1] = 1; fa_op[1] = 40; fd_op[1] = 128'hD;
    step();
    check("same_stage_tie", rd_data_ra, 128'hE);

    // Dual write to the same address
    idle(); wr_en_ep = 1; wr_addr_ep = 50; wr_data_ep = 128'hEE;
    wr_en_op = 1; wr_addr_op = 50; wr_data_op = 128'hDD;
    step();
    check("conflict_pulse", {127'b0, wr_conflict}, 128'd1);
    idle();
    step();
    check("conflict_cleared", {127'b0, wr_conflict}, '0);
    rd_req = 1; rd_addr_ra = 50;
    step();
    check("dual_write_odd", rd_data_ra, 128'hDD);

    // Randomized traffic on a narrow address window to force collisions
    for (int c = 0; c < 400; c++) begin
      rd_req     = ($urandom_range(0, 3) != 0);
      rd_addr_ra = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      rd_addr_rb = AW'($urandom_range(0, 7));
      rd_addr_rc = ($urandom_range(0, 3) == 0) ? rd_addr_ra : AW'($urandom_range(0, 7));
      wr_en_ep   = $urandom_range(0, 1) != 0;
      wr_addr_ep = AW'($urandom_range(0, 7));
      wr_data_ep = rnd128();
      wr_en_op   = $urandom_range(0, 1) != 0;
      wr_addr_op = AW'($urandom_range(0, 7));
      wr_data_op = rnd128();
      for (int s = 0; s < NF; s++) begin
        fwd_vld_ep[s] = ($urandom_range(0, 3) == 0);
        fwd_vld_op[s] = ($urandom_range(0, 3) == 0);
        fa_ep[s] = AW'($urandom_range(0, 7));
        fa_op[s] = AW'($urandom_range(0, 7));
        fd_ep[s] = rnd128();
        fd_op[s] = rnd128();
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
